// File: rtl/dds_wave_gen_if.sv
// Configuration, table-write and DAC signal bundle for dds_wave_gen.
// master = CSR/config side, slave = the generator.
interface dds_wave_gen_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int PHASE_W = 32,
  parameter int AMP_W   = 8
);
  logic               enable;
  logic [2:0]         mode;
  logic [PHASE_W-1:0] freq_word;
  logic [PHASE_W-1:0] phase_offset;
  logic [ADDR_W-1:0]  duty;
  logic [AMP_W-1:0]   amplitude;
  logic [DATA_W-1:0]  dc_offset;
  logic               phase_sync;
  logic               wr_valid;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_clear;
  logic               wave_ready;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0]  dac_out;
  logic               dac_valid;
  logic               dac_clk;

  modport master (
    output enable, mode, freq_word, phase_offset, duty, amplitude, dc_offset,
           phase_sync, wr_valid, wr_data, wr_clear,
    input  wave_ready, wr_ptr, dac_out, dac_valid, dac_clk
  );

  modport slave (
    input  enable, mode, freq_word, phase_offset, duty, amplitude, dc_offset,
           phase_sync, wr_valid, wr_data, wr_clear,
    output wave_ready, wr_ptr, dac_out, dac_valid, dac_clk
  );
endinterface

// File: rtl/dds_wave_gen.sv
// DDS generator: phase acc -> idx (S1) -> RAM/built-in sample (S2) -> gain/offset/saturate (S3) -> DAC.
// Latency 3 cycles src_ok -> dac_valid; no backpressure, the DAC takes every sample.
module dds_wave_gen #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int PHASE_W = 32,
  parameter int AMP_W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dds_wave_gen_if.slave bus
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam int                SUM_W = DATA_W + AMP_W + 1;
  localparam logic [DATA_W-1:0] FULL  = '1;

  typedef enum logic [2:0] {
    MODE_RAM    = 3'd0,
    MODE_SQUARE = 3'd1,
    MODE_TRI    = 3'd2,
    MODE_SAW    = 3'd3,
    MODE_DC     = 3'd4
  } mode_e;

  typedef struct packed {
    logic              from_ram;
    logic [DATA_W-1:0] gen;
  } s2_t;

  // Left-align an ADDR_W value into DATA_W bits (drops LSBs or zero-pads).
  function automatic logic [DATA_W-1:0] align(input logic [ADDR_W-1:0] v);
    logic [ADDR_W+DATA_W-1:0] w;
    w = {v, {DATA_W{1'b0}}};
    return DATA_W'(w >> ADDR_W);
  endfunction

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] phase_sum;
  logic [ADDR_W-1:0]  idx_next;
  logic [ADDR_W-1:0]  idx_r;
  logic [2:0]         stage_vld;
  logic               src_ok;

  logic [DATA_W-1:0]  ram [DEPTH];
  logic [DATA_W-1:0]  ram_q;
  logic [ADDR_W-1:0]  wr_ptr_r;
  logic               wave_ready_r;
  logic               wr_en;

  logic [ADDR_W-1:0]  tri_v;
  logic [DATA_W-1:0]  gen_sample;
  s2_t                s2;

  logic [DATA_W-1:0]  s3_sample;
  logic [SUM_W-1:0]   prod;
  logic [SUM_W-1:0]   sum;
  logic [DATA_W-1:0]  scaled;
  logic [DATA_W-1:0]  dac_out_r;

  // RAM mode stalls until a full table exists.
  assign src_ok    = bus.enable && ((bus.mode != MODE_RAM) || wave_ready_r);
  assign phase_sum = acc + bus.phase_offset;
  assign idx_next  = ADDR_W'(phase_sum >> (PHASE_W - ADDR_W));
  assign wr_en     = bus.wr_valid && !bus.wr_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (bus.phase_sync) begin
      acc <= '0;
    end else if (src_ok) begin
      acc <= acc + bus.freq_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= '0;
      wave_ready_r <= 1'b0;
    end else if (bus.wr_clear) begin
      wr_ptr_r     <= '0;
      wave_ready_r <= 1'b0;
    end else if (bus.wr_valid) begin
      wr_ptr_r <= wr_ptr_r + 1'b1;
      if (wr_ptr_r == ADDR_W'(DEPTH - 1)) begin
        wave_ready_r <= 1'b1;
      end
    end
  end

  // Non-blocking read alongside the write gives old data on an address collision.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_ptr_r] <= bus.wr_data;
    end
    if (stage_vld[0]) begin
      ram_q <= ram[idx_r];
    end
  end

  always_comb begin
    tri_v      = idx_r[ADDR_W-1] ? ~{idx_r[ADDR_W-2:0], 1'b0} : {idx_r[ADDR_W-2:0], 1'b0};
    gen_sample = FULL;
    case (mode_e'(bus.mode))
      MODE_SQUARE: gen_sample = (idx_r < bus.duty) ? FULL : '0;
      MODE_TRI:    gen_sample = align(tri_v);
      MODE_SAW:    gen_sample = align(idx_r);
      default:     gen_sample = FULL;
    endcase
  end

  always_comb begin
    s3_sample = s2.from_ram ? ram_q : s2.gen;
    prod      = SUM_W'(s3_sample) * SUM_W'(bus.amplitude);
    sum       = (prod >> AMP_W) + SUM_W'(bus.dc_offset);
    scaled    = (sum > SUM_W'(FULL)) ? FULL : DATA_W'(sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld <= '0;
      idx_r     <= '0;
      s2        <= '0;
      dac_out_r <= '0;
    end else begin
      stage_vld <= {stage_vld[1:0], src_ok};
      if (src_ok) begin
        idx_r <= idx_next;
      end
      if (stage_vld[0]) begin
        s2 <= '{from_ram: (bus.mode == MODE_RAM), gen: gen_sample};
      end
      if (stage_vld[1]) begin
        dac_out_r <= scaled;
      end
    end
  end

  assign bus.wave_ready = wave_ready_r;
  assign bus.wr_ptr     = wr_ptr_r;
  assign bus.dac_out    = dac_out_r;
  assign bus.dac_valid  = stage_vld[2];
  // Rising edge mid-cycle so the DAC latches a settled sample.
  assign bus.dac_clk    = stage_vld[2] ? ~clk : 1'b0;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: stimulus pushes expected DAC samples,
// a monitor pops and compares on every dac_valid.
module tb_dds_wave_gen;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int PHASE_W = 32;
  localparam int AMP_W   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dds_wave_gen_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W), .AMP_W(AMP_W)) b ();

  dds_wave_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W), .AMP_W(AMP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  int         checks     = 0;
  int         errors     = 0;
  int         valid_seen = 0;
  int         sample_no  = 0;
  bit         mon_en     = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n && b.dac_valid) begin
      valid_seen++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got dac_out=%0d with empty scoreboard", b.dac_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check($sformatf("sample%0d", sample_no), 32'(b.dac_out), 32'(mon_exp));
        end
        check("dac_clk_high", 32'(b.dac_clk), 32'd1);
        sample_no++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_phase();
    b.phase_sync = 1'b1;
    tick(1);
    b.phase_sync = 1'b0;
  endtask

  task automatic play(input int n);
    b.enable = 1'b1;
    tick(n);
    b.enable = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      tick(1);
      t++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    tick(4);
  endtask

  logic [7:0] tri_exp [8] = '{8'd0, 8'd63, 8'd127, 8'd191, 8'd254, 8'd190, 8'd126, 8'd62};
  logic [7:0] saw_exp [8] = '{8'd3, 8'd7, 8'd12, 8'd17, 8'd22, 8'd27, 8'd32, 8'd37};

  initial begin
    int snap;
    int t;
    b.enable       = 1'b0;
    b.mode         = 3'd0;
    b.freq_word    = 32'h0100_0000;
    b.phase_offset = '0;
    b.duty         = '0;
    b.amplitude    = 8'h80;
    b.dc_offset    = '0;
    b.phase_sync   = 1'b0;
    b.wr_valid     = 1'b0;
    b.wr_data      = '0;
    b.wr_clear     = 1'b0;

    #1 rst_n = 1'b0;
    #10;
    check("rst_dac_out", 32'(b.dac_out), 32'd0);
    check("rst_dac_valid", 32'(b.dac_valid), 32'd0);
    check("rst_wr_ptr", 32'(b.wr_ptr), 32'd0);
    check("rst_wave_ready", 32'(b.wave_ready), 32'd0);
    check("rst_dac_clk", 32'(b.dac_clk), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // RAM mode without a table must not produce samples or advance the phase.
    snap = valid_seen;
    play(10);
    tick(4);
    check("no_table_no_valid", 32'(valid_seen - snap), 32'd0);

    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        check("ready_before_last", 32'(b.wave_ready), 32'd0);
        check("ptr_before_last", 32'(b.wr_ptr), 32'd255);
      end
      b.wr_valid = 1'b1;
      b.wr_data  = 8'(i);
      tick(1);
    end
    b.wr_valid = 1'b0;
    check("load_ptr_wrapped", 32'(b.wr_ptr), 32'd0);
    check("load_wave_ready", 32'(b.wave_ready), 32'd1);

    // Ramp playback from the untouched accumulator: i/2.
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i >> 1));
    play(20);
    drain();

    b.phase_offset = 32'h8000_0000;
    sync_phase();
    exp_q.push_back(8'd64);
    exp_q.push_back(8'd64);
    exp_q.push_back(8'd65);
    exp_q.push_back(8'd65);
    play(4);
    drain();
    b.phase_offset = '0;

    b.mode      = 3'd1;
    b.duty      = 8'h40;
    b.amplitude = 8'hFF;
    sync_phase();
    for (int i = 0; i < 300; i++) exp_q.push_back(((i % 256) < 64) ? 8'd254 : 8'd0);
    play(300);
    drain();

    b.mode      = 3'd2;
    b.freq_word = 32'h2000_0000;
    sync_phase();
    for (int i = 0; i < 8; i++) exp_q.push_back(tri_exp[i]);
    play(8);
    drain();

    b.mode      = 3'd3;
    b.freq_word = 32'h0500_0000;
    b.dc_offset = 8'd3;
    sync_phase();
    for (int i = 0; i < 8; i++) exp_q.push_back(saw_exp[i]);
    play(8);
    drain();

    b.mode      = 3'd4;
    b.dc_offset = 8'h10;
    repeat (3) exp_q.push_back(8'd255);
    play(3);
    drain();
    b.dc_offset = 8'h00;
    repeat (3) exp_q.push_back(8'd254);
    play(3);
    drain();
    b.mode = 3'd7;
    repeat (3) exp_q.push_back(8'd254);
    play(3);
    drain();
    b.mode      = 3'd4;
    b.amplitude = 8'h80;
    b.dc_offset = 8'h10;
    repeat (2) exp_q.push_back(8'd143);
    play(2);
    drain();

    // Clear with a simultaneous write while playing the table.
    b.mode      = 3'd0;
    b.dc_offset = 8'h00;
    b.freq_word = 32'h0100_0000;
    sync_phase();
    for (int i = 0; i < 11; i++) exp_q.push_back(8'(i >> 1));
    b.enable = 1'b1;
    tick(10);
    b.wr_clear = 1'b1;
    b.wr_valid = 1'b1;
    b.wr_data  = 8'hAA;
    tick(1);
    b.wr_clear = 1'b0;
    b.wr_valid = 1'b0;
    check("clear_wr_ptr", 32'(b.wr_ptr), 32'd0);
    check("clear_wave_ready", 32'(b.wave_ready), 32'd0);
    tick(3);
    check("clear_valid_dropped", 32'(b.dac_valid), 32'd0);
    b.enable = 1'b0;
    drain();

    // Reset in the middle of a DC run.
    b.wr_valid = 1'b1;
    tick(3);
    b.wr_valid  = 1'b0;
    b.mode      = 3'd4;
    b.amplitude = 8'hFF;
    mon_en      = 1'b0;
    b.enable    = 1'b1;
    t = 0;
    while (!b.dac_valid && t < 20) begin
      tick(1);
      t++;
    end
    tick(1);
    check("pre_reset_valid", 32'(b.dac_valid), 32'd1);
    check("pre_reset_dac_out", 32'(b.dac_out), 32'd254);
    check("pre_reset_wr_ptr", 32'(b.wr_ptr), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dac_out", 32'(b.dac_out), 32'd0);
    check("midrst_dac_valid", 32'(b.dac_valid), 32'd0);
    check("midrst_wr_ptr", 32'(b.wr_ptr), 32'd0);
    check("midrst_wave_ready", 32'(b.wave_ready), 32'd0);
    check("midrst_dac_clk", 32'(b.dac_clk), 32'd0);
    b.enable = 1'b0;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
